sobel_stream: RTL
=================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel bit width.
REQ-002 SHALL have parameter IMG_W, default 352, pixels per line (min 3).
REQ-003 SHALL have parameter IMG_H, default 288, lines per frame (min 3).
REQ-004 SHALL have parameter NORM_SH, default 3, right-shift applied to gradient magnitude.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input pixel valid.
REQ-008 in_ready  out  1  input pixel accepted when in_valid && in_ready.
REQ-009 in_pix  in  PIX_W  unsigned input pixel, raster order.
REQ-010 in_sof  in  1  qualifies in_pix as pixel (0,0) of a frame.
REQ-011 cfg_thresh  in  PIX_W  normalised values <= cfg_thresh output as 0.
REQ-012 cfg_bin  in  1  0 = magnitude output, 1 = binary output (0 or all-ones).
REQ-013 out_valid  out  1  output pixel valid.
REQ-014 out_ready  in  1  output pixel consumed when out_valid && out_ready.
REQ-015 out_pix  out  PIX_W  filtered pixel.
REQ-016 out_eof  out  1  marks last output pixel of a frame.

Function
REQ-017 SHALL track column 0..IMG_W-1 and row 0..IMG_H-1 of each accepted pixel; column wraps to 0 with row increment; row wraps to 0 after IMG_H-1.
REQ-018 Accepted pixel with in_sof=1 SHALL be taken as (0,0) regardless of counter state (resync); line-buffer contents are not cleared.
REQ-019 SHALL hold two line buffers of IMG_W x PIX_W plus a 3x3 window w[r][c] (r,c = 0 top/left) shifted on every accepted pixel.
REQ-020 Accepting pixel (r,c) with r>=2 and c>=2 SHALL compute the kernel centred at (r-1,c-1); otherwise no output is produced (output frame (IMG_H-2)x(IMG_W-2)).
REQ-021 gx = (w02+2*w12+w22) - (w00+2*w10+w20); gy = (w00+2*w01+w02) - (w20+2*w21+w22); signed, PIX_W+4 bits, no overflow.
REQ-022 mag = |gx|+|gy| unsigned PIX_W+4 bits; norm = mag >> NORM_SH saturated to 2^PIX_W-1.
REQ-023 norm <= cfg_thresh -> out_pix = 0; else cfg_bin=0 -> norm, cfg_bin=1 -> 2^PIX_W-1.
REQ-024 Result SHALL be registered into the output stage on the accepting edge: out_valid high in the cycle after acceptance (latency 1).
REQ-025 in_ready = !out_valid || out_ready (combinational); a full, unconsumed output stage SHALL stall input.
REQ-026 out_pix/out_eof SHALL stay stable while out_valid && !out_ready.
REQ-027 Simultaneous consume and new result SHALL replace the output stage with no bubble; consume without new result SHALL clear out_valid.
REQ-028 out_eof SHALL be 1 only for the result from input pixel (IMG_H-1, IMG_W-1).
REQ-029 cfg_thresh/cfg_bin SHALL be sampled at the accepting edge.

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, out_eof=0, out_pix=0, row/column counters=0, window=0; line-buffer contents need not reset.
REQ-031 Reset mid-frame SHALL discard the partial frame; next accepted pixel is (0,0) irrespective of in_sof.

Structure
REQ-032 Package sobel_pkg SHALL hold default parameter values, gradient width function (PIX_W+4) and the cfg_bin mode encoding.
REQ-033 Line buffer SHALL be a sub-module sobel_line_buf (IMG_W-deep, PIX_W-wide, read-before-write single port per accept) instantiated twice.

Verification (IMG_W=8, IMG_H=4, NORM_SH=3, PIX_W=8)
REQ-034 Constant image 100, cfg_thresh=0 -> 12 outputs all 0; out_eof on 12th only.
REQ-035 Vertical step cols0-3=0, cols4-7=255, thresh=20, cfg_bin=0 -> each output row 0,0,127,127,0,0.
REQ-036 Same step, cfg_bin=1, cfg_thresh=126 -> rows 0,0,255,255,0,0; cfg_thresh=127 -> all 0.
REQ-037 Pixel (1,1)=255, rest 0, corner windows give gx=gy=+/-255 -> mag 510, out 63; pixel at gradient 2040 -> out 255 (saturate check).
REQ-038 out_ready low 5 cycles during frame -> in_ready low, out_pix stable; resume with no lost or duplicated pixels (12 outputs).
REQ-039 rst_n pulsed after 10 input pixels, then a full frame -> exactly 12 outputs, first out_valid one cycle after pixel (2,2) accepted.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared defaults, gradient width helper and output-mode encoding for the Sobel stream filter.
package sobel_pkg;

    localparam int unsigned DefPixW   = 8;
    localparam int unsigned DefImgW   = 352;
    localparam int unsigned DefImgH   = 288;
    localparam int unsigned DefNormSh = 3;

    typedef enum logic {
        BinMag    = 1'b0,
        BinThresh = 1'b1
    } bin_mode_e;

    // Signed gradient width; +4 covers the 1+2+1 kernel sum and the sign.
    function automatic int unsigned grad_w(input int unsigned pix_w);
        return pix_w + 4;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixel storage: combinational read and write at the same address each accept.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W = DefPixW,
    parameter int unsigned IMG_W = DefImgW,
    parameter int unsigned AW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Old contents are seen this cycle; the write lands on the edge.
    assign rdata = mem_q[addr];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge filter with valid/ready handshake and a single registered output stage.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned PIX_W   = DefPixW,
    parameter int unsigned IMG_W   = DefImgW,
    parameter int unsigned IMG_H   = DefImgH,
    parameter int unsigned NORM_SH = DefNormSh
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] cfg_thresh,
    input  logic             cfg_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_eof
);

    localparam int unsigned GW = grad_w(PIX_W);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    logic [CW-1:0]    col_q, col_d, pos_col;
    logic [RW-1:0]    row_q, row_d, pos_row;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic             accept, produce, is_last;

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        gx_abs, gy_abs, mag, shifted;
    logic [PIX_W-1:0]     norm, result;

    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_pix_q, out_pix_d;
    logic             out_eof_q, out_eof_d;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_eof   = out_eof_q;

    // lb0 holds the previous line, lb1 the line before that.
    sobel_line_buf #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata (in_pix),
        .rdata (lb0_rd)
    );

    sobel_line_buf #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{(GW - PIX_W){1'b0}}, p});
    endfunction

    always_comb begin
        pos_col = in_sof ? '0 : col_q;
        pos_row = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        if (accept) begin
            if (pos_col == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = in_pix;
        end
    end

    // Kernel is evaluated on the window as it will be after this accept.
    always_comb begin
        gx = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
           - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
        gy = (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]))
           - (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]));
        gx_abs  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        gy_abs  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag     = gx_abs + gy_abs;
        shifted = mag >> NORM_SH;
        norm    = (|shifted[GW-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
        if (norm <= cfg_thresh) begin
            result = '0;
        end else if (bin_mode_e'(cfg_bin) == BinThresh) begin
            result = '1;
        end else begin
            result = norm;
        end
    end

    assign produce = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    assign is_last = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));

    always_comb begin
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        out_eof_d   = out_eof_q;
        if (produce) begin
            out_valid_d = 1'b1;
            out_pix_d   = result;
            out_eof_d   = is_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
            out_eof_q   <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
            out_eof_q   <= out_eof_d;
            win_q       <= win_d;
        end
    end

endmodule
